// File: rtl/bf16_to_fxp_drain.sv
// BF16 to signed fixed-point converter (truncate toward zero, saturate) with a
// credit-reserved output FIFO so downstream backpressure never drops a result.
module bf16_to_fxp_drain #(
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [15:0]                  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [2:0]                   out_flags,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENT_W = OUT_W + 3;
  localparam int unsigned MAG_W = OUT_W + 8;
  localparam int unsigned LSH_W = $clog2(MAG_W);
  localparam logic [MAG_W-1:0] LIM     = MAG_W'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] POS_SAT = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_SAT = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DENORM,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } cls_e;

  logic             w_in_fire;
  cls_e             w_in_cls;
  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [7:0]       r_s1_exp;
  logic [6:0]       r_s1_mant;
  cls_e             r_s1_cls;

  logic [7:0]       w_m;
  int               w_sh;
  logic             w_big;
  logic [MAG_W-1:0] w_mag;
  logic [OUT_W-1:0] w_res;
  logic             w_sat;
  logic             w_nan;
  logic             w_unf;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check counts the word sitting in stage 1 so the FIFO cannot overflow.
  assign in_ready  = rst_n && (({1'b0, r_level} + (LVL_W+1)'(r_s1_valid)) < (LVL_W+1)'(DEPTH));
  assign w_in_fire = in_valid && in_ready;

  always_comb begin
    w_in_cls = CLS_NORMAL;
    if (in_data[14:7] == 8'h00) begin
      w_in_cls = (in_data[6:0] == 7'd0) ? CLS_ZERO : CLS_DENORM;
    end else if (in_data[14:7] == 8'hFF) begin
      w_in_cls = (in_data[6:0] == 7'd0) ? CLS_INF : CLS_NAN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_mant  <= '0;
      r_s1_cls   <= CLS_ZERO;
    end else begin
      r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        r_s1_sign <= in_data[15];
        r_s1_exp  <= in_data[14:7];
        r_s1_mant <= in_data[6:0];
        r_s1_cls  <= w_in_cls;
      end
    end
  end

  // Stage 2: align the significand; shifts past the output range are flagged big.
  always_comb begin
    w_m   = {1'b1, r_s1_mant};
    w_sh  = int'(r_s1_exp) - 134 + int'(FRAC_W);
    w_big = 1'b0;
    w_mag = '0;
    if (w_sh >= int'(OUT_W)) begin
      w_big = 1'b1;
    end else if (w_sh >= 0) begin
      w_mag = MAG_W'(w_m) << LSH_W'(w_sh);
    end else if (w_sh > -8) begin
      w_mag = MAG_W'(w_m >> 3'(-w_sh));
    end

    w_res = '0;
    w_sat = 1'b0;
    w_nan = 1'b0;
    w_unf = 1'b0;
    case (r_s1_cls)
      CLS_DENORM: w_unf = 1'b1;
      CLS_NAN:    w_nan = 1'b1;
      CLS_INF: begin
        w_sat = 1'b1;
        w_res = r_s1_sign ? NEG_SAT : POS_SAT;
      end
      CLS_NORMAL: begin
        if (w_big || (!r_s1_sign && (w_mag >= LIM)) || (r_s1_sign && (w_mag > LIM))) begin
          w_sat = 1'b1;
          w_res = r_s1_sign ? NEG_SAT : POS_SAT;
        end else if (w_mag == '0) begin
          w_unf = 1'b1;
        end else begin
          w_res = r_s1_sign ? (OUT_W'(0) - w_mag[OUT_W-1:0]) : w_mag[OUT_W-1:0];
        end
      end
      default: ;
    endcase
  end

  assign w_push = r_s1_valid;
  assign w_pop  = (r_level != '0) && out_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_unf, w_nan, w_sat, w_res};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Head is gated so stale memory never shows while empty or in reset.
  assign out_valid              = (r_level != '0);
  assign level                  = r_level;
  assign {out_flags, out_data}  = out_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_bf16_to_fxp_drain.sv
// Directed bench for bf16_to_fxp_drain: conversion table, latency, backpressure,
// random-ready streaming and mid-stream reset.
module tb_bf16_to_fxp_drain;

  localparam int DEPTH = 4;
  localparam int NV    = 17;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_flags;
  logic [2:0]  level;

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic [2:0]  flg;
  } vec_t;

  vec_t        vec [NV];
  logic [18:0] got [$];
  int          checks = 0;
  int          errors = 0;

  bf16_to_fxp_drain #(.OUT_W(16), .FRAC_W(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back({out_data, out_flags});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input string name);
    int c = 0;
    while (got.size() < n && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check(name, 32'(got.size()), 32'(n));
  endtask

  // Offer table words 0..n-1 back to back for a bounded number of cycles.
  task automatic offer_burst(input int n, input int cycles, output int accepted);
    int   idx = 0;
    logic rdy;
    in_valid = 1'b1;
    in_data  = vec[0].din;
    for (int c = 0; c < cycles; c++) begin
      if (idx >= n) break;
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) idx++;
      if (idx < n) in_data = vec[idx].din;
    end
    in_valid = 1'b0;
    accepted = idx;
  endtask

  initial begin
    int   acc;
    int   idx;
    int   cyc;
    logic rdy;

    vec[0]  = '{16'h3F80, 16'h0100, 3'b000};
    vec[1]  = '{16'hC040, 16'hFD00, 3'b000};
    vec[2]  = '{16'h4300, 16'h7FFF, 3'b001};
    vec[3]  = '{16'hC300, 16'h8000, 3'b000};
    vec[4]  = '{16'h7F80, 16'h7FFF, 3'b001};
    vec[5]  = '{16'hFF80, 16'h8000, 3'b001};
    vec[6]  = '{16'h7FC0, 16'h0000, 3'b010};
    vec[7]  = '{16'h8000, 16'h0000, 3'b000};
    vec[8]  = '{16'h0001, 16'h0000, 3'b100};
    vec[9]  = '{16'h3B00, 16'h0000, 3'b100};
    vec[10] = '{16'h3B80, 16'h0001, 3'b000};
    vec[11] = '{16'h3F00, 16'h0080, 3'b000};
    vec[12] = '{16'hBB80, 16'hFFFF, 3'b000};
    vec[13] = '{16'h42FF, 16'h7F80, 3'b000};
    vec[14] = '{16'h7F7F, 16'h7FFF, 3'b001};
    vec[15] = '{16'hFF7F, 16'h8000, 3'b001};
    vec[16] = '{16'h0080, 16'h0000, 3'b100};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #23;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_out_flags", 32'(out_flags), 0);
    check("rst_level",     32'(level),     0);
    check("rst_in_ready",  32'(in_ready),  0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Conversion table, with acceptance-to-valid latency on the first word
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      got.delete();
      send(vec[i].din);
      if (i == 0) begin
        check("latency_e0", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("latency_e1", 32'(out_valid), 1);
      end
      wait_out(1, "vec_count");
      check($sformatf("vec_%0d_%h", i, vec[i].din), 32'(got[0]), 32'({vec[i].dout, vec[i].flg}));
    end
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: only DEPTH of six offered words fit
    got.delete();
    out_ready = 1'b0;
    offer_burst(6, 8, acc);
    check("bp_accepted", 32'(acc), 4);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_level",    32'(level), 4);
    check("bp_head_stable", 32'({out_data, out_flags}), 32'({vec[0].dout, vec[0].flg}));
    out_ready = 1'b1;
    send(vec[4].din);
    send(vec[5].din);
    wait_out(6, "bp_count");
    repeat (4) @(posedge clk);
    #1;
    check("bp_no_dup", 32'(got.size()), 6);
    for (int k = 0; k < 6 && k < got.size(); k++)
      check($sformatf("bp_order_%0d", k), 32'(got[k]), 32'({vec[k].dout, vec[k].flg}));

    // Stream 20 words with out_ready toggling; pointers wrap several times
    got.delete();
    idx = 0;
    cyc = 0;
    while ((idx < 20 || got.size() < 20) && cyc < 600) begin
      out_ready = 1'($urandom_range(0, 1));
      if (idx < 20) begin
        in_valid = 1'b1;
        in_data  = vec[idx % NV].din;
      end else begin
        in_valid = 1'b0;
      end
      rdy = in_ready && in_valid;
      @(posedge clk); #1;
      cyc++;
      if (rdy) idx++;
      check("stream_level_bound", 32'(int'(level) > DEPTH), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_out(20, "stream_count");
    for (int k = 0; k < 20 && k < got.size(); k++)
      check($sformatf("stream_%0d", k), 32'(got[k]), 32'({vec[k % NV].dout, vec[k % NV].flg}));

    // Reset with three words buffered and one in stage 1
    got.delete();
    out_ready = 1'b0;
    offer_burst(4, 4, acc);
    check("mid_accepted", 32'(acc), 4);
    check("mid_level", 32'(level), 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_level",     32'(level),     0);
    check("mid_rst_out_data",  32'(out_data),  0);
    check("mid_rst_in_ready",  32'(in_ready),  0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_post_in_ready", 32'(in_ready), 1);
    check("mid_post_level",    32'(level),    0);
    out_ready = 1'b1;
    send(16'h3F80);
    wait_out(1, "mid_count");
    check("mid_first_word", 32'(got[0]), 32'({16'h0100, 3'b000}));
    repeat (5) @(posedge clk);
    #1;
    check("mid_no_stale", 32'(got.size()), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
